systolic_feeder: RTL
====================

// Module: systolic_feeder
// PURPOSE
// - Upstream driver for the NxN systolic PE array: buffers matrix A (NxK) and
//   matrix B (KxN), streams them diagonally skewed into the west (a) and north (b) edges.
// - Sequences the PE array's block/clear controls.
// - Provides the write side of each PE's a/b/block interface; result readout is out of scope.
// PARAMETERS
// - N   4  array dimension (edge rows/cols driven)
// - K   4  inner dimension (columns of A / rows of B)
// - W   8  data width per element
// - IW  3  index width for wr_row/wr_col and step_idx high bits; must cover max(N,K)-1
// PORTS
// - clk       in   1      clock
// - rst       in   1      reset, synchronous, active-high
// - wr_en     in   1      buffer write strobe
// - wr_sel    in   1      0 = write A[row][col], 1 = write B[row][col]
// - wr_row    in   IW     element row index
// - wr_col    in   IW     element column index
// - wr_data   in   W      element value
// - wr_err    out  1      1-cycle pulse: write rejected (busy or index out of range)
// - start     in   1      begin a run (sampled in IDLE only)
// - busy      out  1      run in progress
// - done      out  1      1-cycle pulse after final step
// - a_edge    out  N*W    row i at bits [i*W +: W], to PE(i,0).a
// - b_edge    out  N*W    col j at bits [j*W +: W], to PE(0,j).b
// - pe_block  out  1      array block line; 1 = hold, 0 = accumulate
// - pe_clr    out  1      array reset line (FEEDER_ARR_CLR_EN only, else tied 0)
// - step_idx  out  IW+2   current step t (0 when idle)
// BEHAVIOUR
// - Reset: IDLE; busy=0, done=0, wr_err=0, a_edge=0, b_edge=0, pe_block=1,
//   pe_clr=0, step_idx=0. Buffer contents are not cleared.
// - Steps: S = K + 2N - 2, t = 0..S-1.
//   - a_edge[i] = A[i][t-i] if 0 <= t-i < K, else 0.
//   - b_edge[j] = B[t-j][j] if 0 <= t-j < K, else 0.
// - FSM: IDLE -> (CLR) -> MAC -> SHIFT -> MAC ... -> DONE -> IDLE.
//   - IDLE: pe_block=1, edges 0. start=1 moves to CLR (macro on) or MAC (macro off),
//     step=0. busy=1 from the next cycle.
//   - CLR: 1 cycle, pe_clr=1, pe_block=1.
//   - MAC: 1 cycle. Edges registered with step-t values on entry. pe_block=0.
//   - SHIFT: 1 cycle. pe_block=1; the rising edge makes PEs latch partial sums and
//     forward a/b. Edges hold the step-t values.
//     - If t < S-1: t+1, go to MAC.
//     - Else: go to DONE.
//   - DONE: 1 cycle. done=1, edges 0, pe_block=1, busy=0. Then IDLE.
// - Run length from start: 2S+1 cycles (+1 with CLR).
// - Writes: accepted only in IDLE with wr_row/wr_col in range. Otherwise wr_err
//   pulses the next cycle and the buffer is unchanged.
// - start while busy: ignored, no error.
// - start and wr_en in the same IDLE cycle: the write lands; the run uses the new value.
// - rst mid-run: back to IDLE next edge, all outputs at reset values, no done pulse.
// - Element data passes through unmodified; no arithmetic on values.
//   Index compare uses signed or widened math so t-i never wraps.
// CONFIGURATION
// - FEEDER_ARR_CLR_EN defined: CLR state present; pe_clr pulses 1 cycle before step 0,
//   clearing PE accumulators.
// - FEEDER_ARR_CLR_EN undefined: no CLR state; pe_clr constant 0; array must be
//   cleared by system rst.
// TESTING (N=2, K=2, S=4, bench instantiates 2x2 PE array + reference model)
// - Load A=[[1,2],[3,4]], B=[[5,6],[7,8]], start:
//   - t0: a_edge={0,1}, b_edge={0,5}.
//   - t1: a_edge={3,2}, b_edge={6,7}.
//   - done asserts 2S+1(+1) cycles after start.
//   - PE vals = [[19,22],[43,50]].
// - Write during busy (A[0][0]=9): wr_err=1 for 1 cycle.
//   - Re-run gives the same results as before.
// - Write wr_row=2 while idle: wr_err pulses; buffer unchanged.
// - start pulsed again at t=2: ignored; exactly one done pulse; step_idx sequence 0,1,2,3.
// - rst asserted during SHIFT of t=1:
//   - Next cycle busy=0, pe_block=1, edges 0, no done.
//   - New start reruns correctly.
// - Macro on vs off:
//   - On: pe_clr high exactly 1 cycle, immediately before first MAC.
//   - Off: pe_clr never asserts; run is 1 cycle shorter.

Source files
------------

// File: rtl/systolic_feeder.sv
// -----------------------------------------------------------------------------
// systolic_feeder
//
// Upstream driver for an NxN systolic PE array. Buffers matrix A (NxK) and
// matrix B (KxN) and streams them diagonally skewed into the west (a) and
// north (b) edges of the array. It also sequences the array's block/clear
// lines. Result readout is handled elsewhere.
//
// Sequence: IDLE -> (CLR) -> MAC -> SHIFT -> MAC ... -> DONE -> IDLE
//   S = K + 2N - 2 steps, each step is one MAC cycle followed by one SHIFT
//   cycle. At step t: a_edge[i] = A[i][t-i], b_edge[j] = B[t-j][j] when the
//   inner index lies in 0..K-1, else 0.
//
// Optional feature macro: FEEDER_ARR_CLR_EN
//   defined   : a one-cycle CLR state precedes step 0 and pulses pe_clr_o.
//   undefined : no CLR state, pe_clr_o is constant 0.
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset
//   wr_en_i      buffer write strobe
//   wr_sel_i     0 = write A[row][col], 1 = write B[row][col]
//   wr_row_i     element row index
//   wr_col_i     element column index
//   wr_data_i    element value
//   wr_err_o     one-cycle pulse: write rejected (busy or index out of range)
//   start_i      begin a run (honoured in IDLE only)
//   busy_o       run in progress
//   done_o       one-cycle pulse after the final step
//   a_edge_o     row i at bits [i*W +: W], to PE(i,0).a
//   b_edge_o     col j at bits [j*W +: W], to PE(0,j).b
//   pe_block_o   array block line, 1 = hold, 0 = accumulate
//   pe_clr_o     array accumulator clear line
//   step_idx_o   current step t (0 when idle)
// -----------------------------------------------------------------------------
module systolic_feeder #(
   parameter int N  = 4,
   parameter int K  = 4,
   parameter int W  = 8,
   parameter int IW = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wr_en_i,
   input  logic            wr_sel_i,
   input  logic [IW-1:0]   wr_row_i,
   input  logic [IW-1:0]   wr_col_i,
   input  logic [W-1:0]    wr_data_i,
   output logic            wr_err_o,
   input  logic            start_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [N*W-1:0]  a_edge_o,
   output logic [N*W-1:0]  b_edge_o,
   output logic            pe_block_o,
   output logic            pe_clr_o,
   output logic [IW+1:0]   step_idx_o
);

   localparam int            S         = K + 2*N - 2;
   localparam int            SW        = IW + 2;
   localparam logic [SW-1:0] LAST_STEP = SW'(S - 1);

   typedef enum logic [2:0] {ST_IDLE, ST_CLR, ST_MAC, ST_SHIFT, ST_DONE} state_e;

   state_e         state_q, state_d;
   logic [SW-1:0]  step_q, step_d;
   logic [N*W-1:0] a_edge_q, a_edge_d;
   logic [N*W-1:0] b_edge_q, b_edge_d;
   logic           wr_err_q, wr_err_d;

   logic [W-1:0]   a_mem_q [N][K];
   logic [W-1:0]   b_mem_q [K][N];
   // Buffer contents as they will be after this cycle's write; lets a run
   // started in the same cycle as a write see the new value.
   logic [W-1:0]   a_view [N][K];
   logic [W-1:0]   b_view [K][N];
   logic           a_hit  [N][K];
   logic           b_hit  [K][N];

   logic [N*W-1:0] a_load, b_load;
   logic           wr_in_range, wr_ok;
   logic           load_edges, clear_edges;

   // ---------------------------------------------------------------- writes
   always_comb begin
      if (wr_sel_i)
         wr_in_range = (int'(wr_row_i) < K) && (int'(wr_col_i) < N);
      else
         wr_in_range = (int'(wr_row_i) < N) && (int'(wr_col_i) < K);
   end

   assign wr_ok    = wr_en_i && (state_q == ST_IDLE) && wr_in_range;
   assign wr_err_d = wr_en_i && !wr_ok;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         for (int k = 0; k < K; k++) begin
            a_hit[i][k]  = wr_ok && !wr_sel_i && (int'(wr_row_i) == i) && (int'(wr_col_i) == k);
            a_view[i][k] = a_hit[i][k] ? wr_data_i : a_mem_q[i][k];
         end
      end
      for (int k = 0; k < K; k++) begin
         for (int j = 0; j < N; j++) begin
            b_hit[k][j]  = wr_ok && wr_sel_i && (int'(wr_row_i) == k) && (int'(wr_col_i) == j);
            b_view[k][j] = b_hit[k][j] ? wr_data_i : b_mem_q[k][j];
         end
      end
   end

   // Buffer is deliberately left out of reset so its contents survive rst.
   always_ff @(posedge clk) begin
      for (int i = 0; i < N; i++)
         for (int k = 0; k < K; k++)
            if (a_hit[i][k]) a_mem_q[i][k] <= wr_data_i;
      for (int k = 0; k < K; k++)
         for (int j = 0; j < N; j++)
            if (b_hit[k][j]) b_mem_q[k][j] <= wr_data_i;
   end

   // ------------------------------------------------------ skewed edge mux
   // Edge lane gi carries inner index k where step == gi + k; the equality
   // form never needs a subtraction, so nothing can wrap.
   for (genvar gi = 0; gi < N; gi++) begin : g_edge
      logic [W-1:0] a_sel, b_sel;
      always_comb begin
         a_sel = '0;
         b_sel = '0;
         for (int k = 0; k < K; k++) begin
            if (int'(step_d) == gi + k) begin
               a_sel = a_view[gi][k];
               b_sel = b_view[k][gi];
            end
         end
      end
      assign a_load[gi*W +: W] = a_sel;
      assign b_load[gi*W +: W] = b_sel;
   end

   // -------------------------------------------------------- state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         step_q   <= '0;
         a_edge_q <= '0;
         b_edge_q <= '0;
         wr_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         step_q   <= step_d;
         a_edge_q <= a_edge_d;
         b_edge_q <= b_edge_d;
         wr_err_q <= wr_err_d;
      end
   end

   // ------------------------------------------------------------ next state
   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      load_edges  = 1'b0;
      clear_edges = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               step_d = '0;
`ifdef FEEDER_ARR_CLR_EN
               state_d = ST_CLR;
`else
               state_d    = ST_MAC;
               load_edges = 1'b1;
`endif
            end
         end
         ST_CLR: begin
            state_d    = ST_MAC;
            load_edges = 1'b1;
         end
         ST_MAC: state_d = ST_SHIFT;
         ST_SHIFT: begin
            if (step_q < LAST_STEP) begin
               step_d     = step_q + 1'b1;
               state_d    = ST_MAC;
               load_edges = 1'b1;
            end else begin
               state_d     = ST_DONE;
               clear_edges = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            step_d  = '0;
         end
         default: state_d = ST_IDLE;
      endcase

      // Edges change only on entry to MAC; SHIFT holds the step's values.
      if (load_edges) begin
         a_edge_d = a_load;
         b_edge_d = b_load;
      end else if (clear_edges) begin
         a_edge_d = '0;
         b_edge_d = '0;
      end else begin
         a_edge_d = a_edge_q;
         b_edge_d = b_edge_q;
      end
   end

   // --------------------------------------------------------------- outputs
   always_comb begin
      busy_o     = 1'b0;
      done_o     = 1'b0;
      pe_block_o = 1'b1;
      pe_clr_o   = 1'b0;
      step_idx_o = '0;
      case (state_q)
         ST_CLR: begin
            busy_o = 1'b1;
`ifdef FEEDER_ARR_CLR_EN
            pe_clr_o = 1'b1;
`endif
         end
         ST_MAC: begin
            busy_o     = 1'b1;
            pe_block_o = 1'b0;
            step_idx_o = step_q;
         end
         ST_SHIFT: begin
            busy_o     = 1'b1;
            step_idx_o = step_q;
         end
         ST_DONE: done_o = 1'b1;
         default: ;
      endcase
   end

   assign a_edge_o = a_edge_q;
   assign b_edge_o = b_edge_q;
   assign wr_err_o = wr_err_q;

endmodule
